decimate_avg_iq_nch: RTL and testbench

Multi-channel IQ integrate-and-dump decimator with a runtime-programmable power-of-two rate, rounding, and full AXI-stream backpressure. It averages 2^k consecutive samples per channel and emits one output beat per block. It replaces the strobe-driven front end of the decimate-then-LPF chain: it gives downstream filters a proper tready path and runtime rate control, and handles packet boundaries.

---
 rtl/decimate_avg_iq_nch_if.sv | 14 +
 rtl/decimate_avg_iq_nch.sv | 132 +++++++++++++
 tb/tb_decimate_avg_iq_nch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decimate_avg_iq_nch_if.sv
// AXI-stream style beat bundle for the multi-channel IQ decimator.
// tdata packs channel c at [c*2W +: 2W], I in the upper W bits, Q in the lower W bits.
interface decimate_avg_iq_nch_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NCH        = 2
);
    logic [NCH*2*DATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tlast;
    logic                        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/decimate_avg_iq_nch.sv
// Multi-channel IQ integrate-and-dump decimator: averages 2^k beats per channel with
// round-half-up, runtime rate control and full output backpressure.
module decimate_avg_iq_nch #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned NCH               = 2,
    parameter int unsigned MAX_RATE_LOG2     = 8,
    parameter int unsigned DEFAULT_RATE_LOG2 = 6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               rate_stb,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0] rate_log2,
    decimate_avg_iq_nch_if.slave               s_axis,
    decimate_avg_iq_nch_if.master              m_axis,
    output logic                               dropped
);
    localparam int unsigned RW = $clog2(MAX_RATE_LOG2 + 1);
    localparam int unsigned AW = DATA_WIDTH + MAX_RATE_LOG2;
    localparam int unsigned CW = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;

    logic [RW-1:0]         k_q;
    logic [CW-1:0]         cnt_q;
    logic signed [AW-1:0]  acc_q  [NCH][2];
    logic [DATA_WIDTH-1:0] data_q [NCH][2];
    logic                  valid_q;
    logic                  last_q;
    logic                  dropped_q;

    logic signed [DATA_WIDTH-1:0] smp  [NCH][2];
    logic signed [AW:0]           add  [NCH][2];
    logic signed [AW:0]           sum  [NCH][2];
    logic [DATA_WIDTH-1:0]        mean [NCH][2];
    logic [RW-1:0]                rate_clamped;
    logic [CW-1:0]                cnt_max;
    logic [AW:0]                  rnd;
    logic                         ready;
    logic                         accept;
    logic                         final_beat;

    assign rate_clamped = (rate_log2 > RW'(MAX_RATE_LOG2)) ? RW'(MAX_RATE_LOG2) : rate_log2;
    assign cnt_max      = ~({CW{1'b1}} << k_q);
    // Half an LSB of the result; shifts to zero when k is 0.
    assign rnd          = ({{AW{1'b0}}, 1'b1} << k_q) >> 1;
    assign ready        = !reset && !clear && !rate_stb && (!valid_q || m_axis.tready);
    assign accept       = s_axis.tvalid && ready;
    assign final_beat   = (cnt_q == cnt_max);

    assign s_axis.tready = ready;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tlast  = last_q;
    assign dropped       = dropped_q;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 2; r++) begin
                smp[c][r]  = s_axis.tdata[c*2*DATA_WIDTH + r*DATA_WIDTH +: DATA_WIDTH];
                add[c][r]  = {acc_q[c][r][AW-1], acc_q[c][r]}
                           + {{(AW+1-DATA_WIDTH){smp[c][r][DATA_WIDTH-1]}}, smp[c][r]};
                sum[c][r]  = add[c][r] + rnd;
                mean[c][r] = DATA_WIDTH'(sum[c][r] >>> k_q);
            end
        end
    end

    always_comb begin
        m_axis.tdata = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 2; r++) begin
                m_axis.tdata[c*2*DATA_WIDTH + r*DATA_WIDTH +: DATA_WIDTH] = data_q[c][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q       <= RW'(DEFAULT_RATE_LOG2);
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            dropped_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int r = 0; r < 2; r++) begin
                    acc_q[c][r]  <= '0;
                    data_q[c][r] <= '0;
                end
            end
        end else if (clear) begin
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int r = 0; r < 2; r++) acc_q[c][r] <= '0;
            end
        end else begin
            dropped_q <= 1'b0;
            if (valid_q && m_axis.tready) valid_q <= 1'b0;
            if (rate_stb) begin
                k_q       <= rate_clamped;
                cnt_q     <= '0;
                dropped_q <= (cnt_q != '0);
                for (int c = 0; c < NCH; c++) begin
                    for (int r = 0; r < 2; r++) acc_q[c][r] <= '0;
                end
            end else if (accept) begin
                if (final_beat) begin
                    valid_q <= 1'b1;
                    last_q  <= s_axis.tlast;
                    cnt_q   <= '0;
                    for (int c = 0; c < NCH; c++) begin
                        for (int r = 0; r < 2; r++) begin
                            data_q[c][r] <= mean[c][r];
                            acc_q[c][r]  <= '0;
                        end
                    end
                end else if (s_axis.tlast) begin
                    // Packet ended mid-block: the partial average is meaningless.
                    cnt_q     <= '0;
                    dropped_q <= 1'b1;
                    for (int c = 0; c < NCH; c++) begin
                        for (int r = 0; r < 2; r++) acc_q[c][r] <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                    for (int c = 0; c < NCH; c++) begin
                        for (int r = 0; r < 2; r++) acc_q[c][r] <= AW'(add[c][r]);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_decimate_avg_iq_nch.sv
// Self-checking bench: block-average reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_decimate_avg_iq_nch;
    localparam int W    = 16;
    localparam int NCH  = 2;
    localparam int MAXK = 8;
    localparam int DEFK = 6;
    localparam int RW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          rate_stb = 1'b0;
    logic [RW-1:0] rate_log2 = '0;
    logic          dropped;
    bit            rand_rdy = 1'b0;

    decimate_avg_iq_nch_if #(.DATA_WIDTH(W), .NCH(NCH)) s_if ();
    decimate_avg_iq_nch_if #(.DATA_WIDTH(W), .NCH(NCH)) m_if ();

    decimate_avg_iq_nch #(
        .DATA_WIDTH(W), .NCH(NCH), .MAX_RATE_LOG2(MAXK), .DEFAULT_RATE_LOG2(DEFK)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .rate_stb(rate_stb), .rate_log2(rate_log2),
        .s_axis(s_if), .m_axis(m_if), .dropped(dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endfunction

    function automatic logic [63:0] pack4(input int i0, input int q0, input int i1,
                                          input int q1);
        return {16'(i1), 16'(q1), 16'(i0), 16'(q0)};
    endfunction

    // Reference model state: running per-rail sums of the current block.
    int          m_k = DEFK;
    int          m_n = 0;
    longint      m_sum [NCH][2];
    bit          m_valid = 0, m_last = 0, m_drop = 0, started = 0;
    logic [63:0] m_data = '0;
    logic [63:0] log_d[$];
    bit          log_l[$];
    int          drop_cnt = 0;

    function automatic logic [63:0] log_at(input int i);
        if (i < log_d.size()) return log_d[i];
        return 'x;
    endfunction

    function automatic logic log_last_at(input int i);
        if (i < log_l.size()) return log_l[i];
        return 1'bx;
    endfunction

    function automatic void zero_sums();
        m_n = 0;
        for (int c = 0; c < NCH; c++) for (int r = 0; r < 2; r++) m_sum[c][r] = 0;
    endfunction

    always @(negedge clk) begin : compare
        bit     exp_rdy;
        longint mean;
        exp_rdy = !reset && !clear && !rate_stb && (!m_valid || m_if.tready);
        if (started) begin
            chk("in_tready", 64'(s_if.tready), 64'(exp_rdy));
            chk("out_tvalid", 64'(m_if.tvalid), 64'(m_valid));
            chk("dropped", 64'(dropped), 64'(m_drop));
            if (m_valid) begin
                chk("out_tdata", m_if.tdata, m_data);
                chk("out_tlast", 64'(m_if.tlast), 64'(m_last));
            end
            if (m_if.tvalid && m_if.tready) begin
                log_d.push_back(m_if.tdata);
                log_l.push_back(m_if.tlast);
            end
            if (dropped) drop_cnt++;
        end
        if (reset) begin
            started = 1;
            m_k = DEFK; zero_sums();
            m_valid = 0; m_data = '0; m_last = 0; m_drop = 0;
        end else if (clear) begin
            zero_sums(); m_valid = 0; m_drop = 0;
        end else begin
            m_drop = 0;
            if (m_valid && m_if.tready) m_valid = 0;
            if (rate_stb) begin
                m_drop = (m_n != 0);
                m_k = (int'(rate_log2) > MAXK) ? MAXK : int'(rate_log2);
                zero_sums();
            end else if (s_if.tvalid && exp_rdy) begin
                for (int c = 0; c < NCH; c++)
                    for (int r = 0; r < 2; r++)
                        m_sum[c][r] += longint'($signed(s_if.tdata[c*32 + r*16 +: 16]));
                m_n++;
                if (m_n == (1 << m_k)) begin
                    for (int c = 0; c < NCH; c++) begin
                        for (int r = 0; r < 2; r++) begin
                            mean = (m_sum[c][r] + ((m_k > 0) ? (longint'(1) << (m_k - 1)) : 0))
                                   >>> m_k;
                            m_data[c*32 + r*16 +: 16] = 16'(mean);
                        end
                    end
                    m_valid = 1; m_last = s_if.tlast;
                    zero_sums();
                end else if (s_if.tlast) begin
                    zero_sums(); m_drop = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_if.tready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last);
        bit rdy;
        int t;
        s_if.tdata = d; s_if.tlast = last; s_if.tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); rdy = s_if.tready;
            @(posedge clk); #1; t++;
        end while (!rdy && t < 1000);
        if (!rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no in_tready in %0d cycles, required acceptance", t);
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic do_rate(input int v, output logic got_drop);
        rate_stb = 1'b1; rate_log2 = RW'(v);
        @(negedge clk); chk("rate_stb_ready_low", 64'(s_if.tready), 64'(0));
        @(posedge clk); #1; rate_stb = 1'b0;
        @(negedge clk); got_drop = dropped;
        @(posedge clk); #1;
    endtask

    initial begin
        logic gd;
        int   l0, d0, r;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
        tick(3); reset = 1'b0; tick(1);

        // k=2 basic average with rounding and full-scale channel.
        do_rate(2, gd); chk("t1_no_drop", 64'(gd), 64'(0));
        l0 = log_d.size();
        send_beat(pack4(1, -1, 32767, 32767), 0);
        send_beat(pack4(2, -2, 32767, 32767), 0);
        send_beat(pack4(3, -2, 32767, 32767), 0);
        send_beat(pack4(4, -2, 32767, 32767), 0);
        @(negedge clk); chk("t1_latency", 64'(m_if.tvalid), 64'(1));
        @(posedge clk); #1; tick(2);
        chk("t1_count", 64'(log_d.size()), 64'(l0 + 1));
        chk("t1_data", log_at(l0), pack4(3, -2, 32767, 32767));

        // k=0 pass-through with a 3-cycle output stall.
        do_rate(0, gd);
        l0 = log_d.size();
        fork
            for (int i = 0; i < 10; i++) send_beat(pack4(i, i, i, i), 0);
            begin
                tick(4); m_if.tready = 1'b0;
                @(negedge clk); chk("t2_stall_ready", 64'(s_if.tready), 64'(0));
                @(posedge clk); #1; tick(2); m_if.tready = 1'b1;
            end
        join
        tick(3);
        chk("t2_count", 64'(log_d.size()), 64'(l0 + 10));
        for (int i = 0; i < 10; i++) chk("t2_data", log_at(l0 + i), pack4(i, i, i, i));

        // k=3 with early tlast, then a complete packet.
        do_rate(3, gd);
        d0 = drop_cnt; l0 = log_d.size();
        for (int i = 1; i <= 5; i++) send_beat(pack4(i, -i, 2 * i, 0), i == 5);
        tick(3);
        chk("t3_drop_once", 64'(drop_cnt), 64'(d0 + 1));
        chk("t3_no_output", 64'(log_d.size()), 64'(l0));
        for (int i = 1; i <= 8; i++) send_beat(pack4(8, 8, 8, 8), i == 8);
        tick(3);
        chk("t3_count", 64'(log_d.size()), 64'(l0 + 1));
        chk("t3_data", log_at(l0), pack4(8, 8, 8, 8));
        chk("t3_last", 64'(log_last_at(l0)), 64'(1));

        // Rate change mid-block drops the partial and takes effect at once.
        do_rate(2, gd);
        for (int i = 0; i < 3; i++) send_beat(pack4(7, 7, 7, 7), 0);
        do_rate(1, gd); chk("t4_drop", 64'(gd), 64'(1));
        l0 = log_d.size();
        send_beat(pack4(5, -5, 5, -5), 0);
        send_beat(pack4(6, -6, 6, -6), 0);
        tick(3);
        chk("t4_count", 64'(log_d.size()), 64'(l0 + 1));
        chk("t4_data", log_at(l0), pack4(6, -5, 6, -5));

        // Out-of-range rate clamps to the maximum.
        do_rate(MAXK + 3, gd);
        l0 = log_d.size();
        for (int i = 0; i < 256; i++) send_beat(pack4(-32768, -32768, -32768, -32768), 0);
        tick(3);
        chk("t5_count", 64'(log_d.size()), 64'(l0 + 1));
        chk("t5_data", log_at(l0), 64'h8000_8000_8000_8000);

        // Reset mid-block restores defaults.
        do_rate(2, gd);
        send_beat(pack4(9, 9, 9, 9), 0);
        send_beat(pack4(9, 9, 9, 9), 0);
        reset = 1'b1;
        @(negedge clk); chk("t6_reset_ready", 64'(s_if.tready), 64'(0));
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 64'(m_if.tvalid), 64'(0));
        chk("t6_rst_data", m_if.tdata, 64'(0));
        chk("t6_rst_last", 64'(m_if.tlast), 64'(0));
        chk("t6_rst_drop", 64'(dropped), 64'(0));
        @(posedge clk); #1;
        l0 = log_d.size();
        for (int i = 1; i <= 64; i++) send_beat(pack4(100, 100, 100, 100), i == 64);
        tick(3);
        chk("t6_count", 64'(log_d.size()), 64'(l0 + 1));
        chk("t6_data", log_at(l0), pack4(100, 100, 100, 100));

        // Randomized traffic, backpressure, clears and rate changes.
        rand_rdy = 1'b1;
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                clear = 1'b1; tick(1); clear = 1'b0;
            end else if (r < 5) begin
                do_rate($urandom_range(0, 4), gd);
            end else if (r < 20) begin
                tick(1);
            end else begin
                send_beat({$urandom, $urandom}, $urandom_range(0, 15) == 0);
            end
        end
        rand_rdy = 1'b0;
        tick(1); m_if.tready = 1'b1; tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
